// File: rtl/comparator_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// comparator_ctrl : shadow config + idle/run/paused sequencer for a comparator bank
// rev 1.0
// ---------------------------------------------------------------------------
module comparator_ctrl #(
  parameter int NUM_BITS = 16,
  parameter int NUM_CH   = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         cmd_start_i,
  input  logic                         cmd_stop_i,
  input  logic                         cmd_update_i,
  input  logic                         cmd_reset_i,
  input  logic                         cfg_upd_mode_i,
  input  logic                         cfg_wr_i,
  input  logic [$clog2(NUM_CH)-1:0]    cfg_ch_i,
  input  logic [NUM_BITS-1:0]          cfg_comp_i,
  input  logic [2:0]                   cfg_op_i,
  input  logic                         timer_end_i,
  output logic                         ctrl_active_o,
  output logic                         ctrl_update_o,
  output logic                         ctrl_rst_o,
  output logic [NUM_CH*NUM_BITS-1:0]   cfg_comp_o,
  output logic [NUM_CH*3-1:0]          cfg_comp_op_o,
  output logic                         timer_en_o,
  output logic                         timer_rst_o,
  output logic [1:0]                   state_o,
  output logic                         upd_pending_o
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  state_t state, state_n;
  logic   pending, pending_n;
  logic   upd_n, crst_n, upd_req;

  logic [NUM_BITS-1:0] comp_q [NUM_CH];
  logic [2:0]          op_q   [NUM_CH];

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          comp_q[k] <= '0;
          op_q[k]   <= 3'b000;
        end else if (cfg_wr_i && (cfg_ch_i == CH_W'(k))) begin
          comp_q[k] <= cfg_comp_i;
          op_q[k]   <= cfg_op_i;
        end
      end
      assign cfg_comp_o[k*NUM_BITS +: NUM_BITS] = comp_q[k];
      assign cfg_comp_op_o[k*3 +: 3]            = op_q[k];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      pending       <= 1'b0;
      ctrl_update_o <= 1'b0;
      ctrl_rst_o    <= 1'b0;
      timer_rst_o   <= 1'b0;
      ctrl_active_o <= 1'b0;
      timer_en_o    <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      ctrl_update_o <= upd_n;
      ctrl_rst_o    <= crst_n;
      timer_rst_o   <= crst_n;
      ctrl_active_o <= (state_n == RUN);
      timer_en_o    <= (state_n == RUN);
    end
  end

  // Only the highest-priority asserted command is acted on; timer_end is
  // handled independently of the command set while running.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    upd_n     = 1'b0;
    crst_n    = 1'b0;
    upd_req   = 1'b0;
    if (cmd_reset_i) begin
      state_n   = IDLE;
      pending_n = 1'b0;
      crst_n    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!cmd_stop_i && (cmd_start_i || cmd_update_i)) begin
            upd_n = 1'b1;
            if (cmd_start_i) state_n = RUN;
          end
        end
        RUN: begin
          if (cmd_stop_i) begin
            state_n   = PAUSED;
            upd_n     = pending;
            pending_n = 1'b0;
          end else begin
            upd_req = cmd_update_i && !cmd_start_i;
            if ((upd_req && cfg_upd_mode_i) || (timer_end_i && (pending || upd_req))) begin
              upd_n     = 1'b1;
              pending_n = 1'b0;
            end else if (upd_req) begin
              pending_n = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!cmd_stop_i) begin
            if (cmd_start_i)       state_n = RUN;
            else if (cmd_update_i) upd_n   = 1'b1;
          end
        end
        default: begin
          state_n   = IDLE;
          pending_n = 1'b0;
        end
      endcase
    end
  end

  assign state_o       = state;
  assign upd_pending_o = pending;

endmodule
`default_nettype wire

// File: tb/tb_comparator_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_comparator_ctrl : directed vector table plus randomized run against a model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_comparator_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic start, stop, upd, rst, mode, wr, tend;
  logic [1:0]  ch;
  logic [15:0] comp;
  logic [2:0]  op;
  logic        active, update, crst, ten, trst, pend;
  logic [63:0] comp_o;
  logic [11:0] op_o;
  logic [1:0]  st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparator_ctrl #(.NUM_BITS(16), .NUM_CH(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_start_i(start), .cmd_stop_i(stop), .cmd_update_i(upd), .cmd_reset_i(rst),
    .cfg_upd_mode_i(mode), .cfg_wr_i(wr), .cfg_ch_i(ch), .cfg_comp_i(comp), .cfg_op_i(op),
    .timer_end_i(tend),
    .ctrl_active_o(active), .ctrl_update_o(update), .ctrl_rst_o(crst),
    .cfg_comp_o(comp_o), .cfg_comp_op_o(op_o),
    .timer_en_o(ten), .timer_rst_o(trst), .state_o(st), .upd_pending_o(pend)
  );

  // Reference model: state as 0 idle / 1 run / 2 paused
  int          m_st;
  bit          m_pend, m_upd, m_crst;
  logic [15:0] m_comp [4];
  logic [2:0]  m_op   [4];

  task automatic model_reset();
    m_st = 0; m_pend = 0; m_upd = 0; m_crst = 0;
    for (int i = 0; i < 4; i++) begin m_comp[i] = '0; m_op[i] = '0; end
  endtask

  task automatic model_step();
    int old_st;
    old_st = m_st;
    m_upd  = 0;
    m_crst = 0;
    if (rst) begin
      m_st = 0; m_pend = 0; m_crst = 1;
    end else if (stop) begin
      if (m_st == 1) begin
        m_st = 2;
        if (m_pend) begin m_upd = 1; m_pend = 0; end
      end
    end else if (start) begin
      if (m_st == 0) begin m_st = 1; m_upd = 1; end
      else if (m_st == 2) m_st = 1;
    end else if (upd) begin
      if (m_st != 1 || mode) begin m_upd = 1; m_pend = 0; end
      else m_pend = 1;
    end
    if (old_st == 1 && !rst && !stop && tend && m_pend) begin
      m_upd = 1; m_pend = 0;
    end
    if (wr) begin m_comp[ch] = comp; m_op[ch] = op; end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; upd = 0; rst = 0; mode = 0; wr = 0; tend = 0;
    ch = 0; comp = 0; op = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] ec;
    logic [11:0] eo;
    for (int i = 0; i < 4; i++) begin
      ec[i*16 +: 16] = m_comp[i];
      eo[i*3 +: 3]   = m_op[i];
    end
    chk({tag, "_ctl"}, {st, pend, active, ten, update, crst, trst},
        {2'(m_st), m_pend, (m_st == 1), (m_st == 1), m_upd, m_crst, m_crst});
    chk({tag, "_cfg"}, {op_o, comp_o[51:0]}, {eo, ec[51:0]});
    chk({tag, "_cfghi"}, comp_o[63:52], ec[63:52]);
  endtask

  typedef struct {
    logic start, stop, upd, rst, mode, wr;
    logic [1:0]  ch;
    logic [15:0] comp;
    logic [2:0]  op;
    logic        tend;
    logic [1:0]  e_st;
    logic        e_upd, e_pend, e_act, e_crst;
    logic [15:0] e_c0, e_c1;
    logic [2:0]  e_op3;
  } vec_t;

  function automatic vec_t v(logic sa, logic so, logic up, logic rs, logic md, logic w,
                             logic [1:0] c, logic [15:0] cv, logic [2:0] o, logic te,
                             logic [1:0] es, logic eu, logic ep, logic ea, logic er,
                             logic [15:0] e0, logic [15:0] e1, logic [2:0] e3);
    vec_t r;
    r.start = sa; r.stop = so; r.upd = up; r.rst = rs; r.mode = md; r.wr = w;
    r.ch = c; r.comp = cv; r.op = o; r.tend = te;
    r.e_st = es; r.e_upd = eu; r.e_pend = ep; r.e_act = ea; r.e_crst = er;
    r.e_c0 = e0; r.e_c1 = e1; r.e_op3 = e3;
    return r;
  endfunction

  vec_t vecs [$];

  initial begin
    //         sa so up rs md wr ch comp op te | st up pd ac cr  c0   c1  op3
    vecs.push_back(v(0,0,0,0,0,1,0,100,2,0, 0,0,0,0,0, 100,  0,0)); // 0 write ch0
    vecs.push_back(v(0,0,0,0,0,1,1,200,3,0, 0,0,0,0,0, 100,200,0)); // 1 write ch1
    vecs.push_back(v(1,0,0,0,0,0,0,  0,0,0, 1,1,0,1,0, 100,200,0)); // 2 start loads
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,0, 1,0,0,1,0, 100,200,0));
    vecs.push_back(v(0,0,1,0,0,1,0,150,2,0, 1,0,1,1,0, 150,200,0)); // 4 deferred
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0,0,0,0,0,0,0,0,0,0, 1,0,1,1,0, 150,200,0));
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,1, 1,1,0,1,0, 150,200,0)); // 9 timer end
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,0, 1,0,0,1,0, 150,200,0));
    vecs.push_back(v(0,0,1,0,1,0,0,  0,0,0, 1,1,0,1,0, 150,200,0)); // 11 immediate
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,0, 1,0,0,1,0, 150,200,0));
    vecs.push_back(v(0,0,1,0,0,0,0,  0,0,0, 1,0,1,1,0, 150,200,0)); // 13 pending
    vecs.push_back(v(0,0,1,0,0,0,0,  0,0,0, 1,0,1,1,0, 150,200,0)); // 14 merged
    vecs.push_back(v(0,1,0,0,0,0,0,  0,0,0, 2,1,0,0,0, 150,200,0)); // 15 stop flushes
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,0, 2,0,0,0,0, 150,200,0));
    vecs.push_back(v(1,0,0,0,0,0,0,  0,0,0, 1,0,0,1,0, 150,200,0)); // 17 resume
    vecs.push_back(v(1,1,1,1,0,0,0,  0,0,0, 0,0,0,0,1, 150,200,0)); // 18 all cmds
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,0, 0,0,0,0,0, 150,200,0));
    vecs.push_back(v(0,0,1,0,0,1,3, 77,7,0, 0,1,0,0,0, 150,200,7)); // 20 op 111
    vecs.push_back(v(0,0,0,0,0,0,0,  0,0,0, 0,0,0,0,0, 150,200,7));

    idle_inputs();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {st, pend, active, ten, update, crst, trst}, 8'h00);
    chk("reset_comp", comp_o, 64'h0);
    chk("reset_op", {52'h0, op_o}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start; stop = vecs[i].stop; upd = vecs[i].upd; rst = vecs[i].rst;
      mode = vecs[i].mode; wr = vecs[i].wr; ch = vecs[i].ch; comp = vecs[i].comp;
      op = vecs[i].op; tend = vecs[i].tend;
      tick();
      chk($sformatf("v%0d_state", i), st, vecs[i].e_st);
      chk($sformatf("v%0d_upd", i), update, vecs[i].e_upd);
      chk($sformatf("v%0d_pend", i), pend, vecs[i].e_pend);
      chk($sformatf("v%0d_act", i), {active, ten}, {vecs[i].e_act, vecs[i].e_act});
      chk($sformatf("v%0d_rst", i), {crst, trst}, {vecs[i].e_crst, vecs[i].e_crst});
      chk($sformatf("v%0d_comp", i), comp_o[31:0], {vecs[i].e_c1, vecs[i].e_c0});
      chk($sformatf("v%0d_op3", i), op_o[11:9], vecs[i].e_op3);
    end

    // Asynchronous reset while running with a pending update
    @(negedge clk);
    idle_inputs(); start = 1; tick();
    @(negedge clk);
    idle_inputs(); upd = 1; tick();
    @(negedge clk);
    idle_inputs();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("async_ctl", {st, pend, active, ten, update, crst, trst}, 8'h00);
    chk("async_comp", comp_o, 64'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 7) == 0);
      upd   = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      mode  = 1'($urandom_range(0, 1));
      wr    = ($urandom_range(0, 2) == 0);
      ch    = 2'($urandom_range(0, 3));
      comp  = 16'($urandom);
      op    = 3'($urandom_range(0, 7));
      tend  = ($urandom_range(0, 5) == 0);
      tick();
      check_model("rnd");
    end

    @(negedge clk);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comparator_ctrl.md
# comparator_ctrl

Sequencing controller for a bank of `NUM_CH` comparator channels sharing one timer. It holds a shadow threshold/opcode per channel and runs the channel-bank state machine (idle / run / paused). It generates the `ctrl_active`, `ctrl_update` and `ctrl_rst` strobes for every comparator. Updates are committed either immediately or at the next timer end, so a running PWM period is never torn.

## Interface
Parameters:
- `NUM_BITS`, 16, comparator/timer count width
- `NUM_CH`, 4, number of comparator channels (power of two, ≥2)

Ports:
- `clk_i`  in  1  clock
- `rstn_i`  in  1  reset; one clock; reset is asynchronous and active-low
- `cmd_start_i`  in  1  start/resume pulse
- `cmd_stop_i`  in  1  pause pulse
- `cmd_update_i`  in  1  request commit of shadow config
- `cmd_reset_i`  in  1  abort, clear comparators, return to idle
- `cfg_upd_mode_i`  in  1  0 = defer update to timer end while running, 1 = immediate
- `cfg_wr_i`  in  1  shadow write strobe
- `cfg_ch_i`  in  $clog2(NUM_CH)  shadow write channel index
- `cfg_comp_i`  in  NUM_BITS  threshold to write
- `cfg_op_i`  in  3  opcode to write
- `timer_end_i`  in  1  timer end-of-period pulse
- `ctrl_active_o`  out  1  comparator enable, common to all channels
- `ctrl_update_o`  out  1  one-cycle load strobe, common
- `ctrl_rst_o`  out  1  one-cycle clear strobe, common
- `cfg_comp_o`  out  NUM_CH*NUM_BITS  shadow thresholds; channel k at `[k*NUM_BITS +: NUM_BITS]`
- `cfg_comp_op_o`  out  NUM_CH*3  shadow opcodes; channel k at `[k*3 +: 3]`
- `timer_en_o`  out  1  timer count enable
- `timer_rst_o`  out  1  one-cycle timer clear strobe
- `state_o`  out  2  00 IDLE, 01 RUN, 10 PAUSED
- `upd_pending_o`  out  1  deferred update outstanding

## Operation
- Shadow regs: `cfg_wr_i` writes `cfg_comp_i`/`cfg_op_i` into channel `cfg_ch_i` at the clock edge. `cfg_comp_o`/`cfg_comp_op_o` drive the shadow contents directly. The comparator samples them only on `ctrl_update_o`.
- All opcodes are stored unchecked; 3'b111 passes through.
- Command priority when simultaneous: reset > stop > start > update.
- IDLE:
  - start → RUN, with `ctrl_update_o` pulse (first enable always loads).
  - update → `ctrl_update_o` pulse, stay IDLE.
  - stop → ignored.
- RUN:
  - stop → PAUSED.
  - start → ignored.
  - update with mode=1 → pulse now.
  - update with mode=0 → set pending.
  - `timer_end_i` while pending (or in the same cycle as a deferred update request) → pulse, clear pending.
- PAUSED:
  - start → RUN.
  - update → pulse immediately regardless of mode.
  - stop → ignored.
- Transition RUN→PAUSED with pending set: the pulse is issued with the transition and pending is cleared.
- reset (any state): → IDLE, `ctrl_rst_o` and `timer_rst_o` pulse, pending cleared, shadow regs kept.
- `ctrl_active_o` = `timer_en_o` = (state == RUN).
- Repeated update requests while pending: merged, one pulse.

## Timing
- All outputs registered. A command sampled at edge N takes effect on outputs after edge N; strobes are high exactly one cycle.
- IDLE start: `ctrl_update_o` and `ctrl_active_o` rise in the same cycle, so the comparator loads its config on the first active edge.
- Deferred update: `timer_end_i` sampled at edge N → `ctrl_update_o` high after edge N, `upd_pending_o` low after edge N.
- Shadow write and update at the same edge: the update pulse follows the write, so the new value is loaded.
- Reset values:
  - state IDLE; pending 0.
  - All strobes 0; `ctrl_active_o` 0; `timer_en_o` 0.
  - Shadow thresholds 0; opcodes 3'b000.
- `rstn_i` mid-operation clears everything immediately and asynchronously.
- `cmd_reset_i` is synchronous and does not clear the shadows.

## Test plan
- Reset, then write ch0=100/op 3'b010 and ch1=200/op 3'b011, then start. Expect a `ctrl_update_o` pulse, `ctrl_active_o`=1, `state_o`=01, `cfg_comp_o[15:0]`=100 and `cfg_comp_o[31:16]`=200 in the pulse cycle.
- In RUN with mode=0: write ch0=150, update. Expect `upd_pending_o`=1 and no pulse. Pulse `timer_end_i` 5 cycles later; expect exactly one `ctrl_update_o` the next cycle and pending=0.
- In RUN with mode=1: update. Expect a pulse one cycle later and pending never set.
- In RUN: set pending, then stop. Expect `state_o`=10, one update pulse, pending=0, `ctrl_active_o`=0. Start again; expect RUN and no extra pulse.
- Assert start, stop, update and reset in the same cycle. Expect IDLE, `ctrl_rst_o`=1 and `timer_rst_o`=1 for one cycle, no update pulse, and shadow values retained.
- Write `cfg_ch_i`=3 with op 3'b111 and update in IDLE. Expect `cfg_comp_op_o[11:9]`=3'b111, one pulse, and state still IDLE.
